// File: rtl/hb3_pkg.sv
// hb3_pkg: shared sequencer state encoding and default build constants for the HB3 motor block.
package hb3_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SETTLE} hb3_state_t;
  localparam int PWM_WIDTH_DEF  = 8;
  localparam int CLK_DIV_DEF    = 4;
  localparam int DEAD_TICKS_DEF = 16;
endpackage

// File: rtl/hb3_tick_gen.sv
// hb3_tick_gen: prescaler producing one tick every CLK_DIV clocks, restartable by a synchronous clear.
module hb3_tick_gen import hb3_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hb3_motor_ctrl.sv
// hb3_motor_ctrl: PWM and direction sequencer for the PmodHB3 bridge with dead time around every reversal.
module hb3_motor_ctrl import hb3_pkg::*; #(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int DEAD_TICKS = DEAD_TICKS_DEF,
  parameter int PWM_WIDTH  = PWM_WIDTH_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 cfg_valid,
  input  logic                 cfg_enable,
  input  logic                 cfg_dir,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  output logic                 hb_en,
  output logic                 hb_dir,
  output logic                 busy,
  output logic                 period_start
);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  hb3_state_t state, nxt;
  logic en_sh, dir_sh, tick, clr, wrap, dead_done;
  logic [PWM_WIDTH-1:0] duty_sh, duty_act, pwm_cnt;
  logic [DW-1:0] dead_cnt;
  assign wrap = tick && (pwm_cnt == '1);
  assign dead_done = tick && (dead_cnt == DW'(DEAD_TICKS - 1));
  assign clr = (nxt != state) && (nxt != IDLE);
  // A pending reversal always outranks the enable request.
  always_comb begin
    nxt = (state == IDLE || state == RUN) ? (dir_sh != hb_dir ? DRAIN : en_sh ? RUN : IDLE) :
          !dead_done ? state :
          state == DRAIN ? SETTLE :
          en_sh ? RUN : IDLE;
  end
  hb3_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .clr(clr),
    .tick(tick)
  );
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= IDLE;
      en_sh <= 1'b0;
      dir_sh <= 1'b0;
      duty_sh <= '0;
      duty_act <= '0;
      pwm_cnt <= '0;
      dead_cnt <= '0;
      hb_en <= 1'b0;
      hb_dir <= 1'b0;
      busy <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (cfg_valid) begin
        en_sh <= cfg_enable;
        dir_sh <= cfg_dir;
        duty_sh <= cfg_duty;
      end
      state <= nxt;
      busy <= (nxt == DRAIN) || (nxt == SETTLE);
      hb_en <= (state == RUN) && (pwm_cnt < duty_act);
      period_start <= (state == RUN) && (nxt == RUN) && wrap;
      if (state == DRAIN && dead_done) hb_dir <= dir_sh;
      dead_cnt <= (nxt != state) ? '0 : ((state == DRAIN || state == SETTLE) && tick) ? dead_cnt + 1'b1 : dead_cnt;
      // Duty only changes at a period boundary so the output never glitches mid-period.
      if (nxt == RUN && state != RUN) begin
        pwm_cnt <= '0;
        duty_act <= duty_sh;
      end else if (state == RUN && tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (wrap) duty_act <= duty_sh;
      end
    end
endmodule

// File: tb/tb_hb3_motor_ctrl.sv
// tb_hb3_motor_ctrl: directed checks of PWM, duty extremes, reversal dead time and reset behaviour.
module tb_hb3_motor_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_enable = 1'b0, cfg_dir = 1'b0;
  logic [7:0] cfg_duty = '0;
  logic hb_en, hb_dir, busy, period_start;
  int checks = 0, errors = 0, hi = 0, ps = 0;
  always #5 clk = ~clk;
  hb3_motor_ctrl #(.CLK_DIV(4), .DEAD_TICKS(16), .PWM_WIDTH(8)) dut (
    .ACLK(clk),
    .ARESET(rst),
    .cfg_valid(cfg_valid),
    .cfg_enable(cfg_enable),
    .cfg_dir(cfg_dir),
    .cfg_duty(cfg_duty),
    .hb_en(hb_en),
    .hb_dir(hb_dir),
    .busy(busy),
    .period_start(period_start)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      hi += int'(hb_en);
      ps += int'(period_start);
    end
  endtask
  task automatic wr(input logic en, input logic dir, input logic [7:0] duty);
    cfg_valid = 1'b1;
    cfg_enable = en;
    cfg_dir = dir;
    cfg_duty = duty;
    step(1);
    cfg_valid = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(hb_en), 0);
    chk({tag, "_dir"}, 32'(hb_dir), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ps"}, 32'(period_start), 0);
  endtask
  initial begin
    step(3);
    chk_all_zero("rst_hold");
    rst = 1'b0;
    step(10);
    chk_all_zero("rst_idle");
    // Enable with duty 64: high one cycle later than RUN entry
    wr(1'b1, 1'b0, 8'd64);
    chk("lat_shadow", 32'(hb_en), 0);
    step(1);
    chk("lat_run", 32'(hb_en), 0);
    step(1);
    chk("lat_high", 32'(hb_en), 1);
    step(1023);
    chk("first_ps", 32'(period_start), 1);
    hi = 0; ps = 0;
    step(1024);
    chk("d64_high", 32'(hi), 256);
    chk("d64_ps_cnt", 32'(ps), 1);
    chk("d64_ps_at_end", 32'(period_start), 1);
    // Mid-period write of 128 at pwm_cnt=10
    hi = 0; ps = 0;
    step(40);
    chk("mid_pre", 32'(hi), 40);
    wr(1'b1, 1'b0, 8'd128);
    step(983);
    chk("mid_keep64", 32'(hi), 256);
    chk("mid_ps", 32'(period_start), 1);
    hi = 0; ps = 0;
    step(1024);
    chk("d128_high", 32'(hi), 512);
    chk("d128_ps", 32'(ps), 1);
    wr(1'b1, 1'b0, 8'd255);
    step(1023);
    hi = 0; ps = 0;
    step(1024);
    chk("d255_high", 32'(hi), 1020);
    chk("d255_ps", 32'(ps), 1);
    wr(1'b1, 1'b0, 8'd0);
    step(1023);
    hi = 0; ps = 0;
    step(1024);
    chk("d0_high", 32'(hi), 0);
    chk("d0_ps", 32'(ps), 1);
    wr(1'b1, 1'b0, 8'd64);
    step(1023);
    step(20);
    chk("pre_rev_en", 32'(hb_en), 1);
    // Reversal from RUN; k counts cycles after the DRAIN entry edge
    wr(1'b1, 1'b1, 8'd64);
    step(1);
    chk("rev_busy", 32'(busy), 1);
    step(1);
    chk("rev_en_low", 32'(hb_en), 0);
    step(62);
    chk("rev_dir_k63", 32'(hb_dir), 0);
    step(1);
    chk("rev_dir_k64", 32'(hb_dir), 1);
    chk("rev_settle_busy", 32'(busy), 1);
    step(63);
    chk("rev_busy_k127", 32'(busy), 1);
    step(1);
    chk("rev_busy_k128", 32'(busy), 0);
    chk("rev_en_k128", 32'(hb_en), 0);
    step(1);
    chk("rev_en_k129", 32'(hb_en), 1);
    hi = 0; ps = 0;
    step(1023);
    chk("rev_restart_ps", 32'(period_start), 1);
    chk("rev_restart_cnt", 32'(ps), 1);
    chk("rev_restart_high", 32'(hi), 255);
    wr(1'b1, 1'b0, 8'd64);
    step(140);
    chk("back_dir", 32'(hb_dir), 0);
    chk("back_busy", 32'(busy), 0);
    // Revert direction and disable while draining
    wr(1'b1, 1'b1, 8'd64);
    step(1);
    chk("drn_busy", 32'(busy), 1);
    step(10);
    wr(1'b0, 1'b0, 8'd64);
    step(53);
    chk("drn_dir_k64", 32'(hb_dir), 0);
    chk("drn_settle_busy", 32'(busy), 1);
    step(64);
    chk("drn_busy_k128", 32'(busy), 0);
    hi = 0;
    step(20);
    chk("drn_idle_high", 32'(hi), 0);
    chk("drn_idle_dir", 32'(hb_dir), 0);
    chk("drn_idle_busy", 32'(busy), 0);
    // Asynchronous reset in RUN after a reversal to dir=1
    wr(1'b1, 1'b1, 8'd64);
    step(200);
    chk("prerst_en", 32'(hb_en), 1);
    chk("prerst_dir", 32'(hb_dir), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    step(2);
    rst = 1'b0;
    step(20);
    chk_all_zero("rst_after");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hb3_motor_ctrl.md
# hb3_motor_ctrl

Motor-drive sequencer for the PmodHB3 H-bridge peripheral. Sits between the AXI4-Lite register file and the bridge pins. Converts a latched enable/direction/duty configuration into a glitch-free PWM on the bridge enable pin. Guarantees the direction pin never changes while the bridge is driven, inserting a dead time before and after every reversal.

## Interface
Parameters:
- CLK_DIV, 4, ACLK cycles per PWM tick (≥2)
- DEAD_TICKS, 16, PWM ticks for each of the drain and settle phases (≥1)
- PWM_WIDTH, 8, duty/counter width; period = 2^PWM_WIDTH ticks

Ports:
- ACLK  in  1  clock. One clock domain for the whole block.
- ARESET  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  one-cycle strobe from the register write; latches the cfg_* fields
- cfg_enable  in  1  requested bridge enable
- cfg_dir  in  1  requested direction
- cfg_duty  in  PWM_WIDTH  requested duty, in ticks high per period
- hb_en  out  1  registered PWM to the bridge EN pin
- hb_dir  out  1  registered bridge DIR pin
- busy  out  1  high while a direction reversal is in progress
- period_start  out  1  one-cycle pulse when the PWM counter wraps to 0 in RUN

## Operation
- **Shadow registers.** en_sh, dir_sh and duty_sh load on cfg_valid and are visible on the following cycle. cfg_valid is accepted in every state.
- **Tick generator.** Prescale counter runs 0..CLK_DIV-1. tick is asserted on the cycle the counter equals CLK_DIV-1. The counter clears on entry to RUN, DRAIN and SETTLE.
- **PWM counter.** PWM_WIDTH bits, advances on tick, wraps from max to 0. It clears on entry to RUN.
- **Duty update.** duty_act reloads from duty_sh on RUN entry and on each wrap only. Mid-period duty writes never take effect mid-period.
- **States:**
  - IDLE: hb_en low.
  - RUN: hb_en follows the compare pwm_cnt < duty_act.
  - DRAIN: hb_en low; waits DEAD_TICKS ticks.
  - SETTLE: hb_en low; waits DEAD_TICKS ticks.
- **Transitions, evaluated each cycle in priority order:**
  - IDLE: dir_sh≠hb_dir → DRAIN; else en_sh → RUN.
  - RUN: dir_sh≠hb_dir → DRAIN; else !en_sh → IDLE.
  - DRAIN: on the DEAD_TICKS-th tick, set hb_dir ← dir_sh and go to SETTLE.
  - SETTLE: on the DEAD_TICKS-th tick, go to RUN if en_sh, else IDLE.
- **Writes during a reversal.** Writes during DRAIN/SETTLE update the shadows only; the sequence never aborts.
  - If dir_sh reverts during DRAIN, hb_dir still loads dir_sh (no change) and SETTLE still runs.
  - A new mismatch arising in SETTLE is handled from RUN/IDLE afterwards.
- **Duty extremes.**
  - duty 0 gives hb_en constantly low in RUN.
  - duty max gives hb_en low for 1 tick per period.
- **busy** = state ∈ {DRAIN, SETTLE}, registered.

## Timing
- **Reset values:** hb_en=0, hb_dir=0, busy=0, period_start=0; state IDLE; all counters and shadows 0. Reset asserted mid-reversal forces these values immediately (asynchronous).
- **hb_en:** hb_en(t+1) = (state(t)==RUN) && (pwm_cnt(t) < duty_act(t)).
  - Leaving RUN drops hb_en on the first cycle after the state change.
- **Latency, cfg_valid (enable=1, dir unchanged) in IDLE:** shadow at t+1, RUN at t+2, hb_en high at t+3 when duty>0.
- **Reversal:** from the DRAIN entry edge, hb_dir changes after exactly DEAD_TICKS·CLK_DIV cycles. RUN is re-entered after a further DEAD_TICKS·CLK_DIV cycles.
- **Collisions:** tick and wrap in the same cycle as a state change are the cases to check. The state change wins, and counters clear per the entry rules.
- **period_start:** asserted the cycle after the wrap tick, RUN only.

## Structure
- **Package hb3_pkg:** the state enum (IDLE, RUN, DRAIN, SETTLE) and the default PWM_WIDTH, CLK_DIV and DEAD_TICKS constants. Shared with the register-file wrapper.
- **Sub-module hb3_tick_gen:** prescaler with a synchronous clear input and a tick output.
- **Top hb3_motor_ctrl:** shadows, PWM counter, dead-time counter and FSM. Target size 150-250 lines.

## Test plan
All scenarios use CLK_DIV=4, DEAD_TICKS=16, PWM_WIDTH=8.
- **Reset:** assert ARESET mid-RUN → all outputs 0 in the same cycle. Deassert with no cfg_valid → outputs stay 0.
- **Steady PWM:** write enable=1, dir=0, duty=64 → hb_en high 256 and low 768 cycles per 1024-cycle period. period_start every 1024 cycles.
- **Duty edges:**
  - duty=0 → hb_en never high.
  - duty=255 → hb_en low exactly 4 cycles per period.
- **Mid-period duty change:** write duty=128 at pwm_cnt=10 → the current period keeps 64. The next period's high time is 512 cycles.
- **Reversal in RUN:** write dir=1 → hb_en low within 2 cycles and busy high. hb_dir toggles 64 cycles after DRAIN entry. RUN resumes 64 cycles later, then busy drops and PWM restarts at count 0.
- **Writes during DRAIN:** revert dir=0 and write enable=0 during DRAIN → hb_dir stays 0 and SETTLE completes. The FSM ends in IDLE with hb_en low.
